// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
// popcount is only needed when GRAY_CHECK_EN is defined.
package gray_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Purely combinational WIDTH-bit binary-to-Gray encoder.
module gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [MAX_W-1:0] wide;

  assign wide = bin2gray(MAX_W'(bin));
  assign gray = wide[WIDTH-1:0];

  // The encoder works at package width; bits above WIDTH are always zero.
  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^wide[MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Binary count sequencer presenting each value with its Gray code under valid/ready.
// Optional macro GRAY_CHECK_EN adds a sticky gray_err single-bit-step monitor.
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int unsigned TERM  = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             busy,
  output logic             done
`ifdef GRAY_CHECK_EN
  ,
  output logic             gray_err
`endif
);

  localparam logic [WIDTH-1:0] TERM_V = TERM[WIDTH-1:0];

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             at_term;

  assign at_term = dir ? (count_reg == TERM_V) : (count_reg == '0);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    unique case (state_reg)
      IDLE: begin
        if (load) count_next = load_val;
        if (start) state_next = RUN;
      end
      RUN: begin
        // stop wins over a simultaneous handshake: the value is not consumed
        if (stop) begin
          state_next = IDLE;
        end else if (ready) begin
          if (at_term) begin
            if (oneshot) state_next = DONE;
            else         count_next = dir ? '0 : '1;
          end else begin
            count_next = dir ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Encoding the next count lets gray_o leave a register alongside bin_o.
  gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin  (count_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      gray_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      gray_reg  <= gray_next;
    end
  end

  assign valid  = (state_reg == RUN);
  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign bin_o  = count_reg;
  assign gray_o = gray_reg;

`ifdef GRAY_CHECK_EN
  // gray_reg is the value being accepted; compare it with the one replacing it.
  logic stepped;
  assign stepped = (state_reg == RUN) && !stop && ready && !(at_term && oneshot);

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_err <= 1'b0;
    end else if (stepped && (popcount(MAX_W'(gray_next ^ gray_reg)) != 1)) begin
      gray_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench: directed test-plan steps, then random stimulus vs a reference model.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, load, dir, oneshot, ready;
  logic [3:0] load_val;
  logic       valid, busy, done;
  logic [3:0] bin_o, gray_o;
`ifdef GRAY_CHECK_EN
  logic       gray_err;
`endif

  gray_seq_ctrl #(.WIDTH(4), .TERM(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .oneshot  (oneshot),
    .ready    (ready),
    .valid    (valid),
    .bin_o    (bin_o),
    .gray_o   (gray_o),
    .busy     (busy),
    .done     (done)
`ifdef GRAY_CHECK_EN
    ,
    .gray_err (gray_err)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model: mode 0 = idle, 1 = running, 2 = completion cycle
  int m_mode  = 0;
  int m_count = 0;
  int gtab[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Gray table built by the reflect-and-prefix construction.
  task automatic build_gtab();
    gtab[0] = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | (1 << k);
      end
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_count = 0;
    end else if (m_mode == 0) begin
      if (load) m_count = int'(load_val);
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (stop) m_mode = 0;
      else if (ready) begin
        $display("xfer bin=%0d gray=%04b dir=%0d oneshot=%0d", m_count, gtab[m_count][3:0], dir, oneshot);
        if (dir && m_count == 15 && oneshot)      m_mode = 2;
        else if (!dir && m_count == 0 && oneshot) m_mode = 2;
        else if (dir)                             m_count = (m_count + 1) % 16;
        else                                      m_count = (m_count + 15) % 16;
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("valid", valid, (m_mode == 1) ? 1 : 0);
    check("busy",  busy,  (m_mode == 1) ? 1 : 0);
    check("done",  done,  (m_mode == 2) ? 1 : 0);
    check("bin",   bin_o, m_count);
    check("gray",  gray_o, gtab[m_count]);
`ifdef GRAY_CHECK_EN
    check("gray_err", gray_err, 0);
`endif
  endtask

  task automatic begin_run(input logic [3:0] v, input logic d, input logic os, input logic rdy);
    load = 1'b1; load_val = v; start = 1'b1; dir = d; oneshot = os; ready = rdy; stop = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
  endtask

  task automatic end_run();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  int exp_bin[4]  = '{5, 6, 7, 8};
  int exp_gray[4] = '{4'b0111, 4'b0101, 4'b0100, 4'b1100};

  initial begin
    build_gtab();
    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; load_val = '0;
    dir = 1'b1; oneshot = 1'b0; ready = 1'b0;
    repeat (3) tick();
    check("rst_bin", bin_o, 0);
    check("rst_valid", valid, 0);
    rst = 1'b0;

    // load+start: 5,6,7,8 on consecutive cycles
    begin_run(4'd5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("seq_bin", bin_o, exp_bin[i]);
      check("seq_gray", gray_o, exp_gray[i]);
      if (i < 3) tick();
    end
    end_run();

    // one-shot up to the terminal value
    begin_run(4'd14, 1'b1, 1'b1, 1'b1);
    check("os_gray14", gray_o, 4'b1001);
    tick();
    check("os_gray15", gray_o, 4'b1000);
    tick();
    check("os_done", done, 1);
    check("os_valid", valid, 0);
    tick();
    check("os_idle_done", done, 0);
    check("os_idle_bin", bin_o, 15);

    // down-count wrap
    begin_run(4'd0, 1'b0, 1'b0, 1'b1);
    check("dn_gray0", gray_o, 4'b0000);
    tick();
    check("dn_gray15", gray_o, 4'b1000);
    tick();
    check("dn_bin14", bin_o, 14);
    end_run();

    // back-pressure at 9
    begin_run(4'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_gray", gray_o, 4'b1101);
      tick();
    end
    ready = 1'b1;
    tick();
    check("stall_bin", bin_o, 10);
    check("stall_gray10", gray_o, 4'b1111);
    end_run();

    // stop beats a simultaneous handshake; restart re-presents the value
    begin_run(4'd3, 1'b1, 1'b0, 1'b0);
    ready = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0; ready = 1'b0;
    check("stop_valid", valid, 0);
    check("stop_bin", bin_o, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_bin", bin_o, 3);
    check("restart_valid", valid, 1);
    end_run();

    // reset mid-run at 7
    begin_run(4'd7, 1'b1, 1'b0, 1'b0);
    ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_bin", bin_o, 0);
    check("midrst_busy", busy, 0);

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 3) == 0);
      load_val = 4'($urandom_range(0, 15));
      dir      = 1'($urandom_range(0, 1));
      oneshot  = ($urandom_range(0, 3) == 0);
      ready    = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
- Sequencer that steps an internal binary count register and presents each value with its Gray-code equivalent under a valid/ready handshake.
- Used wherever a Gray-coded stream is needed: FIFO pointers, rotary encoder emulation, and test pattern sources.
- Wraps a combinational binary-to-Gray encoder.
- Adds run/hold/one-shot sequencing, load, up/down direction and terminal-count detection.

Parameters:
- WIDTH, 4, bit width of the count and of the Gray output.
- TERM, 2**WIDTH-1, terminal binary value for up-counting; the terminal value for down-counting is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin or resume sequencing; sampled in IDLE only.
- stop  in  1  abort sequencing; sampled in RUN only.
- load  in  1  load load_val into the count; honoured in IDLE only.
- load_val  in  WIDTH  binary preload value.
- dir  in  1  1 = increment, 0 = decrement; sampled at each advance.
- oneshot  in  1  1 = stop after the terminal value is consumed, 0 = wrap; sampled at each advance.
- ready  in  1  consumer accepts the current value.
- valid  out  1  bin_o/gray_o hold a value to be consumed.
- bin_o  out  WIDTH  registered binary count.
- gray_o  out  WIDTH  registered Gray code of bin_o.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on one-shot completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, bin_o=0, gray_o=0, valid=0, busy=0, done=0.
- Output timing: bin_o and gray_o are updated on the same edge.
  - gray_o = bin_o ^ (bin_o>>1) at all times after reset.
  - There is no combinational path from any input to any output.
- States: IDLE, RUN, DONE.
- IDLE:
  - valid=0.
  - load=1: count <= load_val at the next edge.
  - start=1: go to RUN.
  - load and start in the same cycle: the loaded value is the first value presented in RUN.
  - stop is ignored.
- RUN:
  - valid=1 and busy=1. The first presented value appears the cycle after start.
  - valid&&ready (advance):
    - dir=1: count+1.
    - dir=0: count-1.
    - Arithmetic is modulo 2**WIDTH.
  - valid&&!ready: bin_o/gray_o are held stable; no advance.
  - Advance while at the terminal value (count==TERM with dir=1, or count==0 with dir=0):
    - oneshot=1: count is unchanged and the next state is DONE.
    - oneshot=0: wrap (TERM->0 or 0->2**WIDTH-1; with TERM < 2**WIDTH-1, up-wrap still goes to 0) and stay in RUN.
  - stop=1: go to IDLE at the next edge, count retained. stop has priority over a simultaneous advance, so the value is not consumed. load in RUN is ignored.
- DONE:
  - Lasts exactly one cycle: done=1, valid=0, busy=0, then IDLE.
  - start in DONE is ignored.
- rst in any state returns to the reset values at the next edge, including mid-handshake. A value pending consumption is discarded.

Optional Feature:
- Macro: GRAY_CHECK_EN.
- Defined:
  - Adds output gray_err (1 bit, reset 0).
  - Keeps a register of the previously accepted gray_o.
  - On every advance, gray_err is set sticky if the popcount of (new gray ^ previous gray) != 1.
  - Cleared only by rst.
- Undefined:
  - The port and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package gray_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - function bin2gray;
  - function popcount (used under GRAY_CHECK_EN).
- One sub-module, gray_enc: purely combinational WIDTH-bit binary-to-Gray encoder, instantiated on the next-count path so gray_o is registered.

Test Plan (WIDTH=4, TERM=15):
- Reset, then hold rst 3 cycles -> bin_o=0, gray_o=0, valid=0, busy=0, done=0.
- load=1, load_val=4'b0101 with start=1, ready=1, dir=1, oneshot=0 -> first value bin 5/gray 0111, then 6/0101, 7/0100, 8/1100 on consecutive cycles.
- From bin 14, dir=1, oneshot=1, ready=1 -> 14/1001, 15/1000, then done pulses one cycle, valid=0, then IDLE with bin_o=15.
- dir=0, oneshot=0, start from 0, ready=1 -> 0/0000, 15/1000, 14/1001 (wrap).
- valid=1, ready low for 5 cycles at bin 9 -> gray_o=1101 stable for 5 cycles; ready high -> bin 10/1111 next cycle.
- stop and ready both high at bin 3 -> IDLE with bin_o=3; a later start re-presents 3. rst asserted mid-RUN at bin 7 -> all outputs 0 next edge. With GRAY_CHECK_EN, gray_err stays 0 over a full 16-value wrap.
